fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing block for the single-issue MIPS core.
- Produces the instruction word, and the opcode/funct fields, that feed the main control decoder.
- Consumes the decoder's Branch/Jump/Jal/Jr outputs, plus the ALU zero flag and the rs register value, to compute the next PC.
- Fetches from instruction memory over a req/ready handshake and holds each instruction until the datapath releases it.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; held until imem_ready
imem_addr  out  32  fetch address, equal to pc
imem_ready  in  1  imem_rdata valid this cycle; completes the request
imem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction word
opcode  out  6  instr[31:26], to decoder
funct  out  6  instr[5:0], to decoder
instr_valid  out  1  instr/opcode/funct hold a valid instruction
stall  in  1  datapath not ready to retire the current instruction
branch  in  1  from decoder
zero  in  1  ALU equality result for the current instruction
jump  in  1  from decoder
jal  in  1  from decoder
jr  in  1  from decoder
rs_data  in  32  register rs value, used by jr
pc  out  32  address of the current instruction
link_pc  out  32  pc+4, written to $31 on jal
illegal_op  out  1  sticky: an unsupported opcode was issued
misalign_err  out  1  sticky: a jr target had nonzero bits [1:0]
retired  out  32  count of retired instructions

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=S_IDLE, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0.
  - illegal_op=0, misalign_err=0, retired=0.
  - Reset overrides everything. Asserting it mid-fetch drops imem_req next cycle and discards any in-flight response.
- State machine:
  - S_IDLE: entered after reset. Go to S_FETCH on the next edge (one bubble cycle).
  - S_FETCH: imem_req=1, imem_addr=pc. Hold the request and address stable until imem_ready=1. On ready, latch instr<=imem_rdata, go to S_ISSUE.
    - imem_ready in the same cycle the state is entered completes the fetch; minimum fetch latency is 1 cycle.
  - S_ISSUE: instr_valid=1, imem_req=0.
    - stall=1: hold everything.
    - stall=0: pc<=next_pc, retired<=retired+1 (wraps at 2^32), go to S_FETCH.
- imem_ready outside S_FETCH is ignored.
- next_pc is combinational from the current instr and the control inputs. Priority, highest first:
  1. jr: target = {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, set misalign_err.
  2. jump (covers j and jal): target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. branch & zero: target = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
  4. Otherwise: pc_plus4.
- pc_plus4 = pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Control inputs are sampled only in S_ISSUE with stall=0 (the retire cycle). Values in other cycles are don't-care.
- Illegal opcode: in the retire cycle, if opcode is not in {00,02,03,04,23,2B} (hex), set illegal_op.
  - For such an instruction, next_pc is forced to pc_plus4 and all control inputs are ignored, because the decoder drives X.
- link_pc = pc_plus4 at all times.
- opcode and funct are slices of the instr register, so they are stable for the whole S_ISSUE period.
- Sticky flags clear only on reset.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW;
  - FUNCT_JR;
  - the fetch state encoding {S_IDLE, S_FETCH, S_ISSUE};
  - RESET_PC default.
- One combinational sub-module, next_pc_sel, owns the PC-target arithmetic and priority mux. Its inputs are pc, instr, rs_data, branch, zero, jump, jr and an illegal flag. Its outputs are next_pc and a misaligned flag.

Test Plan:
- Reset, then sequential fetch, imem_ready=1 every S_FETCH, stall=0, opcode 00 with jump/jr/branch=0:
  - imem_addr sequence 0,4,8,C;
  - instr_valid pulses 1 cycle per instruction;
  - retired=4 after 4 issues.
- beq at pc=0x10, imm=16'hFFFC, branch=1, zero=1 -> next imem_addr=0x04. Same with zero=0 -> 0x14.
- jal at pc=0x0000_0020, target field 26'h0000100, jump=1, jal=1:
  - link_pc=0x24 during issue;
  - next imem_addr=0x0000_0400.
- jr with both jr=1 and jump=1 driven, rs_data=0x0000_0102 -> next imem_addr=0x100, misalign_err=1 and stays 1.
- Held ready/stall:
  - imem_ready held 0 for 3 cycles -> imem_req and imem_addr held stable throughout.
  - stall=1 for 2 cycles in S_ISSUE -> pc, instr and retired unchanged; advance on the first stall=0.
- opcode 6'h3F issued -> illegal_op=1, next pc=pc+4.
- Reset asserted during a pending fetch -> imem_req=0 next cycle; first post-reset fetch address=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path.
//   - Opcode / funct constants recognised by the fetch unit.
//   - Fetch FSM state encoding.
//   - Default reset PC.
//   - is_legal_op(): true for every opcode the core supports.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus.
//   imem_req   : fetch request, held until imem_ready
//   imem_addr  : word-aligned fetch address
//   imem_ready : imem_rdata valid this cycle, completes the request
//   imem_rdata : fetched instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection (purely combinational).
// Inputs : pc, instr, rs_data, branch, zero, jump, jr, illegal
// Outputs: next_pc   - target of the instruction at pc
//          misaligned - jr target had nonzero low bits (only when jr wins)
// Priority: illegal > jr > jump > taken branch > pc+4.
module next_pc_sel (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic        illegal,
    output logic [31:0] next_pc,
    output logic        misaligned
);
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;

    // Opcode bits are consumed by the caller's legality check, not here.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[31:26];

    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc_plus4 + br_offset;
    assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign jr_target = {rs_data[31:2], 2'b00};

    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        // The decoder drives X on its controls for an unknown opcode, so
        // they must not be looked at at all in that case.
        if (!illegal) begin
            if (jr) begin
                next_pc    = jr_target;
                misaligned = |rs_data[1:0];
            end else if (jump) begin
                next_pc = j_target;
            end else if (branch && zero) begin
                next_pc = br_target;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing for the single-issue MIPS core.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem (master)     : instruction-memory req/ready bus, imem_addr == pc
//   instr/opcode/funct: latched instruction and decoder fields
//   instr_valid       : instruction held in S_ISSUE
//   stall             : datapath cannot retire the current instruction
//   branch/zero/jump/jal/jr/rs_data : next-PC controls, sampled at retire
//   pc, link_pc       : current pc and pc+4
//   illegal_op, misalign_err : sticky error flags
//   retired           : retired-instruction count (wraps)
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic               jal,
    input  logic               jr,
    input  logic [31:0]        rs_data,
    output logic [31:0]        pc,
    output logic [31:0]        link_pc,
    output logic               illegal_op,
    output logic               misalign_err,
    output logic [31:0]        retired
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         illegal_q, illegal_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  retired_q, retired_d;

    logic         illegal_now;
    logic [31:0]  next_pc;
    logic         jr_misaligned;

    // jal only matters to the register-file write of link_pc; the PC target
    // is the same as for j.
    logic unused_jal;
    assign unused_jal = jal;

    assign illegal_now = !is_legal_op(instr_q[31:26]);

    next_pc_sel u_next_pc_sel (
        .pc         (pc_q),
        .instr      (instr_q),
        .rs_data    (rs_data),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .jr         (jr),
        .illegal    (illegal_now),
        .next_pc    (next_pc),
        .misaligned (jr_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        illegal_d     = illegal_q;
        misalign_d    = misalign_q;
        retired_d     = retired_q;

        case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                imem_req_d = 1'b1;
            end
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Retire cycle: the only point the control inputs are used.
                if (!stall) begin
                    pc_d          = next_pc;
                    retired_d     = retired_q + 32'd1;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    state_d       = S_FETCH;
                    if (illegal_now)   illegal_d  = 1'b1;
                    if (jr_misaligned) misalign_d = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
                imem_req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            illegal_q     <= 1'b0;
            misalign_q    <= 1'b0;
            retired_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            illegal_q     <= illegal_d;
            misalign_q    <= misalign_d;
            retired_q     <= retired_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;

    assign instr        = instr_q;
    assign opcode       = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign instr_valid  = instr_valid_q;
    assign pc           = pc_q;
    assign link_pc      = pc_q + 32'd4;
    assign illegal_op   = illegal_q;
    assign misalign_err = misalign_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic        instr_valid;
    logic        stall, branch, zero, jump, jal, jr;
    logic [31:0] rs_data, pc, link_pc, retired;
    logic        illegal_op, misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic        m_illegal, m_misalign;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem_bus.master),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch       (branch),
        .zero         (zero),
        .jump         (jump),
        .jal          (jal),
        .jr           (jr),
        .rs_data      (rs_data),
        .pc           (pc),
        .link_pc      (link_pc),
        .illegal_op   (illegal_op),
        .misalign_err (misalign_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, independent of any RTL structure.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input logic br, input logic z, input logic j,
                                               input logic r, input logic [31:0] rs,
                                               output logic mis, output logic ill);
        logic [31:0] p4;
        logic [5:0]  op;
        int          off;
        p4  = p + 32'd4;
        op  = ins[31:26];
        ill = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h23, 6'h2B});
        mis = 1'b0;
        if (ill) return p4;
        if (r) begin
            mis = (rs % 4) != 0;
            return rs - (rs % 4);
        end
        if (j) return {p4[31:28], ins[25:0], 2'b00};
        if (br && z) begin
            off = $signed(ins[15:0]);
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic junk_controls();
        logic [31:0] r;
        r = $urandom();
        branch = r[0]; zero = r[1]; jump = r[2]; jal = r[3]; jr = r[4];
        rs_data = $urandom();
    endtask

    // One full fetch/issue/retire of instruction `ins`.
    task automatic run_instr(input logic [31:0] ins, input int rdly, input int stl,
                             input logic br, input logic z, input logic j, input logic jl,
                             input logic r, input logic [31:0] rs);
        int          n;
        logic [31:0] exp_pc;
        logic        mis, ill;
        n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("imem_req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("imem_addr", imem_bus.imem_addr, m_pc);
        for (int k = 0; k < rdly; k++) begin
            imem_bus.imem_ready = 1'b0;
            imem_bus.imem_rdata = $urandom();
            junk_controls();
            tick();
            chk("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
            chk("addr_held", imem_bus.imem_addr, m_pc);
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = ins;
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = $urandom();
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, ins);
        chk("opcode", {26'd0, opcode}, {26'd0, ins[31:26]});
        chk("funct", {26'd0, funct}, {26'd0, ins[5:0]});
        chk("pc", pc, m_pc);
        chk("link_pc", link_pc, m_pc + 32'd4);
        chk("req_low_issue", {31'd0, imem_bus.imem_req}, 32'd0);
        for (int k = 0; k < stl; k++) begin
            stall = 1'b1;
            junk_controls();
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, ins);
            chk("stall_retired", retired, m_retired);
        end
        stall = 1'b0;
        branch = br; zero = z; jump = j; jal = jl; jr = r; rs_data = rs;
        exp_pc = model_next(m_pc, ins, br, z, j, r, rs, mis, ill);
        tick();
        junk_controls();
        m_pc       = exp_pc;
        m_retired  = m_retired + 32'd1;
        m_illegal  = m_illegal | ill;
        m_misalign = m_misalign | mis;
        chk("pc_next", pc, m_pc);
        chk("retired", retired, m_retired);
        chk("instr_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_illegal});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_misalign});
    endtask

    task automatic nop(input int rdly, input int stl);
        run_instr(32'h0000_0020, rdly, stl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_retired = 32'd0; m_illegal = 1'b0; m_misalign = 1'b0;
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] rv, ins;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h23, 6'h2B, 6'h3F, 6'h0F};
        reset = 1'b1; stall = 1'b0;
        branch = 0; zero = 0; jump = 0; jal = 0; jr = 0; rs_data = 0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        // reset state
        chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_flags", {30'd0, illegal_op, misalign_err}, 32'd0);
        tick();
        chk("idle_bubble_req", {31'd0, imem_bus.imem_req}, 32'd1);

        // sequential fetch 0,4,8,C
        for (int i = 0; i < 4; i++) nop(0, 0);
        chk("retired_4", retired, 32'd4);

        // beq taken at 0x10, imm=-4 -> 0x04
        chk("pc_0x10", m_pc, 32'h10);
        run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("beq_taken", imem_bus.imem_addr, 32'h04);
        for (int i = 0; i < 3; i++) nop(0, 0);
        run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("beq_not_taken", imem_bus.imem_addr, 32'h14);

        // jal at 0x20
        for (int i = 0; i < 3; i++) nop(0, 0);
        run_instr({6'h03, 26'h0000100}, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("jal_target", imem_bus.imem_addr, 32'h400);

        // jr beats jump, misaligned rs
        run_instr({6'h00, 5'd5, 15'd0, 6'h08}, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0102);
        chk("jr_target", imem_bus.imem_addr, 32'h100);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);

        // ready held low 3 cycles, stall 2 cycles
        nop(3, 2);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);

        // illegal opcode with junk controls
        run_instr({6'h3F, 26'h3FF_FFFF}, 0, 0, 1, 1, 1, 1, 1, 32'h1234_5677);
        chk("illegal_set", {31'd0, illegal_op}, 32'd1);

        // pc wrap: jr to 0xFFFFFFFC then a nop wraps to 0
        run_instr({6'h00, 5'd5, 15'd0, 6'h08}, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        nop(0, 0);
        chk("pc_wrap", imem_bus.imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 50; i++) begin
            rv  = $urandom();
            ins = $urandom();
            ins[31:26] = ops[rv[2:0]];
            run_instr(ins, int'(rv[4:3] % 3), int'(rv[6:5] % 3),
                      rv[7], rv[8], rv[9] & rv[10], rv[11], rv[12] & rv[13] & rv[14],
                      $urandom());
        end

        // reset during a pending fetch; the in-flight response is discarded
        imem_bus.imem_ready = 1'b0;
        tick();
        chk("pend_req", {31'd0, imem_bus.imem_req}, 32'd1);
        reset = 1'b1;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_ready = 1'b0;
        reset = 1'b0;
        model_reset();
        chk("rst_mid_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mid_instr", instr, 32'd0);
        chk("rst_mid_flags", {30'd0, illegal_op, misalign_err}, 32'd0);
        chk("rst_mid_retired", retired, 32'd0);
        nop(0, 0);
        chk("post_rst_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
